// File: rtl/color_decoder.sv
// color_decoder: decodes RGB332 particle colors to counts and totals them per frame.
// Define COLOR_DECODER_ILLEGAL_CNT_EN to add the per-frame illegal_cnt output.
module color_decoder #(
   parameter int color_nbits = 8,
   parameter int NUM_PIXELS  = 307200,
   parameter int SUM_W       = 24
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [color_nbits-1:0] in_color,
   input  logic                   in_sof,
   output logic                   count_valid,
   output logic [2:0]             count_out,
   output logic                   illegal,
   output logic [SUM_W-1:0]       frame_sum,
   output logic                   frame_done,
   output logic                   frame_abort
`ifdef COLOR_DECODER_ILLEGAL_CNT_EN
   ,output logic [15:0]           illegal_cnt
`endif
);
   localparam int PW = $clog2(NUM_PIXELS + 1);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t           state_q, state_d;
   logic [SUM_W-1:0] acc_q, acc_d, frame_sum_q;
   logic [PW-1:0]    pix_q, pix_d;
   logic [2:0]       dec_cnt, count_q;
   logic             dec_ill, xfer, count_valid_q, illegal_q, frame_done_q, frame_abort_q;

   assign in_ready = state_q != DONE;
   assign xfer     = in_valid & in_ready;

   always_comb begin
      dec_cnt = 3'd0;
      dec_ill = 1'b0;
      case (in_color)
         color_nbits'(8'h00): dec_cnt = 3'd0;
         color_nbits'(8'hFF): dec_cnt = 3'd1;
         color_nbits'(8'hFC): dec_cnt = 3'd2;
         color_nbits'(8'hF8): dec_cnt = 3'd3;
         color_nbits'(8'hF4): dec_cnt = 3'd4;
         color_nbits'(8'hF0): dec_cnt = 3'd5;
         color_nbits'(8'hEC): dec_cnt = 3'd6;
         default:             dec_ill = 1'b1;
      endcase
   end

   // An in_sof restarts the frame from either IDLE or ACCUM; completion is checked on the updated count.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      pix_d   = pix_q;
      case (state_q)
         IDLE, ACCUM: begin
            if (xfer && in_sof) begin
               acc_d   = SUM_W'(dec_cnt);
               pix_d   = PW'(1);
               state_d = ACCUM;
            end else if (xfer && state_q == ACCUM) begin
               acc_d = acc_q + SUM_W'(dec_cnt);
               pix_d = pix_q + PW'(1);
            end
            if (xfer && (in_sof || state_q == ACCUM) && pix_d == PW'(NUM_PIXELS))
               state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         acc_q         <= '0;
         pix_q         <= '0;
         frame_sum_q   <= '0;
         count_q       <= '0;
         count_valid_q <= 1'b0;
         illegal_q     <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_abort_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         acc_q         <= acc_d;
         pix_q         <= pix_d;
         count_valid_q <= xfer;
         count_q       <= xfer ? dec_cnt : 3'd0;
         illegal_q     <= xfer & dec_ill;
         frame_done_q  <= state_q == DONE;
         frame_abort_q <= xfer & in_sof & (state_q == ACCUM);
         if (state_q == DONE)
            frame_sum_q <= acc_q;
      end
   end

`ifdef COLOR_DECODER_ILLEGAL_CNT_EN
   logic [15:0] ill_q, ill_d, illegal_cnt_q;

   always_comb begin
      ill_d = ill_q;
      if (xfer && in_sof && state_q != DONE)
         ill_d = 16'(dec_ill);
      else if (xfer && state_q == ACCUM)
         ill_d = (ill_q == 16'hFFFF) ? ill_q : ill_q + 16'(dec_ill);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ill_q         <= '0;
         illegal_cnt_q <= '0;
      end else begin
         ill_q <= ill_d;
         if (state_q == DONE)
            illegal_cnt_q <= ill_q;
      end
   end

   assign illegal_cnt = illegal_cnt_q;
`endif

   assign count_valid = count_valid_q;
   assign count_out   = count_q;
   assign illegal     = illegal_q;
   assign frame_sum   = frame_sum_q;
   assign frame_done  = frame_done_q;
   assign frame_abort = frame_abort_q;
endmodule

// File: doc/color_decoder.md
COLOR_DECODER -- requirements
Module: color_decoder

Interface
REQ-001 SHALL have parameter color_nbits, default 8, pixel color width (RGB332).
REQ-002 SHALL have parameter NUM_PIXELS, default 307200, pixels per frame (640x480).
REQ-003 SHALL have parameter SUM_W, default 24, width of frame particle sum.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  pixel present on in_color.
REQ-007 in_ready  output  1  block accepts pixel this cycle.
REQ-008 in_color  input  color_nbits  RGB332 pixel read from framebuffer.
REQ-009 in_sof  input  1  qualifies in_color as first pixel of a frame.
REQ-010 count_valid  output  1  one-cycle pulse, count_out/illegal valid.
REQ-011 count_out  output  3  decoded particle count 0..6.
REQ-012 illegal  output  1  accepted pixel matched no legal color.
REQ-013 frame_sum  output  SUM_W  particle total of last completed frame.
REQ-014 frame_done  output  1  one-cycle pulse, frame_sum updated.
REQ-015 frame_abort  output  1  one-cycle pulse, frame restarted by early in_sof.

Function
REQ-016 Transfer SHALL occur when in_valid and in_ready are both 1 in a cycle.
REQ-017 Decode table SHALL be: 0x00->0, 0xFF->1, 0xFC->2, 0xF8->3, 0xF4->4, 0xF0->5, 0xEC->6.
REQ-018 Any other in_color SHALL decode to count_out=0 with illegal=1.
REQ-019 count_valid, count_out, illegal SHALL be registered, asserted the cycle after a transfer (latency 1), in every state.
REQ-020 FSM states SHALL be IDLE, ACCUM, DONE; in_ready=1 in IDLE and ACCUM, 0 in DONE.
REQ-021 IDLE: transfer with in_sof=1 SHALL load accumulator with its count, pixel counter with 1, go ACCUM; transfer without in_sof SHALL be decoded but not accumulated.
REQ-022 ACCUM: transfer with in_sof=0 SHALL add count to accumulator and increment pixel counter.
REQ-023 ACCUM: transfer with in_sof=1 SHALL pulse frame_abort next cycle and restart as in REQ-021, staying in ACCUM.
REQ-024 Transfer making pixel count equal NUM_PIXELS SHALL go DONE; NUM_PIXELS=1 frames SHALL go IDLE->DONE directly.
REQ-025 DONE SHALL last exactly one cycle: frame_sum <= accumulator (including last pixel), frame_done=1, then IDLE.
REQ-026 frame_sum SHALL hold its value until the next frame_done; accumulator SHALL not wrap for 6*NUM_PIXELS < 2^SUM_W.
REQ-027 in_valid=0 SHALL stall without changing accumulator or counter in any state.

Reset
REQ-028 reset_n=0 SHALL immediately force state IDLE, accumulator 0, pixel counter 0, frame_sum 0, count_out 0, and count_valid, illegal, frame_done, frame_abort 0.
REQ-029 Reset mid-frame SHALL discard the partial frame; no frame_done SHALL follow until a new in_sof frame completes.

Configuration
REQ-030 Macro COLOR_DECODER_ILLEGAL_CNT_EN defined: SHALL add output illegal_cnt (16 bits), count of illegal pixels in last completed frame, updated with frame_sum, saturating at 0xFFFF, reset 0.
REQ-031 Macro undefined: illegal_cnt port and its logic SHALL not exist; all other behaviour identical.

Verification
REQ-032 NUM_PIXELS=4, in_sof on 0xFF, then 0xFC, 0xF8, 0xEC, valid every cycle -> count_out 1,2,3,6 at latency 1; frame_done one cycle after last count_valid; frame_sum=12; in_ready=0 for that one cycle.
REQ-033 NUM_PIXELS=4, frame 0x00,0x13,0xF0,0xF4 -> illegal=1 only for 0x13, frame_sum=9; with COLOR_DECODER_ILLEGAL_CNT_EN illegal_cnt=1.
REQ-034 Two pixels in ACCUM then in_sof with 0xFF + 3 pixels 0xFF -> frame_abort pulse, frame_sum=4.
REQ-035 Pixels without in_sof in IDLE (0xFF x3) -> count_valid pulses, no frame_done, frame_sum stays 0.
REQ-036 reset_n low for 1 cycle after 2 pixels of a frame, then full 0xEC frame -> all outputs 0 during reset, frame_sum=24.
REQ-037 in_valid toggled randomly across a 0xF8 frame -> frame_sum=12, counts unaffected by stalls.
